id_ex_pipe_reg: RTL and testbench

//  ID/EX pipeline register of the RV32IM pipeline, directly downstream of the decode-stage control unit.

---
 rtl/id_ex_pipe_reg.sv | 151 +++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//   ID/EX pipeline register for the RV32IM pipeline. Latches the decoded
//   control word and operands for EX, detects load-use hazards against the
//   instruction now in EX, and inserts a bubble when one is found. Honours an
//   external stall (hold everything) and flush (next EX slot becomes bubble).
//   A saturating counter records how many bubbles have been inserted.
//
// Ports
//   CLK, RESET          clock (rising edge), async active-low reset
//   STALL_IN, FLUSH_IN  external hold / branch-taken flush
//   ID_*                decoded instruction fields from the control unit
//   EX_*                registered copies driven into EX and forwarding
//   EX_VALID            EX slot holds a real instruction
//   HAZARD_STALL        load-use hold request to PC and IF/ID
//   BUBBLE_COUNT        bubbles inserted since reset (saturating)
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             STALL_IN,
    input  logic             FLUSH_IN,
    input  logic [XLEN-1:0]  ID_PC,
    input  logic [XLEN-1:0]  ID_DATA1,
    input  logic [XLEN-1:0]  ID_DATA2,
    input  logic [XLEN-1:0]  ID_IMM,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic [4:0]       ID_RD,
    input  logic             ID_RS1_USED,
    input  logic             ID_RS2_USED,
    input  logic             ID_ALU_SEL1,
    input  logic             ID_ALU_SEL2,
    input  logic [4:0]       ID_ALU_OP,
    input  logic [2:0]       ID_BRANCH,
    input  logic [1:0]       ID_MEM_WRITE,
    input  logic [2:0]       ID_MEM_READ,
    input  logic [1:0]       ID_WB_SEL,
    input  logic             ID_WRITE_EN,
    output logic [XLEN-1:0]  EX_PC,
    output logic [XLEN-1:0]  EX_DATA1,
    output logic [XLEN-1:0]  EX_DATA2,
    output logic [XLEN-1:0]  EX_IMM,
    output logic [4:0]       EX_RS1,
    output logic [4:0]       EX_RS2,
    output logic [4:0]       EX_RD,
    output logic             EX_ALU_SEL1,
    output logic             EX_ALU_SEL2,
    output logic [4:0]       EX_ALU_OP,
    output logic [2:0]       EX_BRANCH,
    output logic [1:0]       EX_MEM_WRITE,
    output logic [2:0]       EX_MEM_READ,
    output logic [1:0]       EX_WB_SEL,
    output logic             EX_WRITE_EN,
    output logic             EX_VALID,
    output logic             HAZARD_STALL,
    output logic [CNT_W-1:0] BUBBLE_COUNT
);

    // NOP encodings of the side-effecting control fields. A bubble carries
    // these so it can never write the RF, touch memory or redirect fetch.
    localparam logic       DIS  = 1'b0;
    localparam logic [1:0] NO_W = 2'b00;
    localparam logic [2:0] NO_R = 3'b000;
    localparam logic [2:0] B_NO = 3'b000;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic rs1_match;
    logic rs2_match;
    logic load_bubble;

    // Load-use: the load in EX delivers its data too late for the consumer
    // in ID. rd=x0 and bubbles never produce a usable result, so ignore them.
    assign rs1_match    = ID_RS1_USED && (ID_RS1 == EX_RD);
    assign rs2_match    = ID_RS2_USED && (ID_RS2 == EX_RD);
    assign HAZARD_STALL = EX_VALID && (EX_MEM_READ != NO_R) && (EX_RD != 5'd0)
                          && (rs1_match || rs2_match);

    // Flush overrides stall; a hazard only bubbles when the pipe is moving.
    // Flush together with a hazard is still a single bubble.
    assign load_bubble = FLUSH_IN || (!STALL_IN && HAZARD_STALL);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            EX_VALID     <= 1'b0;
            EX_PC        <= '0;
            EX_DATA1     <= '0;
            EX_DATA2     <= '0;
            EX_IMM       <= '0;
            EX_RS1       <= '0;
            EX_RS2       <= '0;
            EX_RD        <= '0;
            EX_ALU_SEL1  <= 1'b0;
            EX_ALU_SEL2  <= 1'b0;
            EX_ALU_OP    <= '0;
            EX_BRANCH    <= B_NO;
            EX_MEM_WRITE <= NO_W;
            EX_MEM_READ  <= NO_R;
            EX_WB_SEL    <= '0;
            EX_WRITE_EN  <= DIS;
        end else if (load_bubble) begin
            EX_VALID     <= 1'b0;
            EX_PC        <= '0;
            EX_DATA1     <= '0;
            EX_DATA2     <= '0;
            EX_IMM       <= '0;
            EX_RS1       <= '0;
            EX_RS2       <= '0;
            EX_RD        <= '0;
            EX_ALU_SEL1  <= 1'b0;
            EX_ALU_SEL2  <= 1'b0;
            EX_ALU_OP    <= '0;
            EX_BRANCH    <= B_NO;
            EX_MEM_WRITE <= NO_W;
            EX_MEM_READ  <= NO_R;
            EX_WB_SEL    <= '0;
            EX_WRITE_EN  <= DIS;
        end else if (!STALL_IN) begin
            EX_VALID     <= 1'b1;
            EX_PC        <= ID_PC;
            EX_DATA1     <= ID_DATA1;
            EX_DATA2     <= ID_DATA2;
            EX_IMM       <= ID_IMM;
            EX_RS1       <= ID_RS1;
            EX_RS2       <= ID_RS2;
            EX_RD        <= ID_RD;
            EX_ALU_SEL1  <= ID_ALU_SEL1;
            EX_ALU_SEL2  <= ID_ALU_SEL2;
            EX_ALU_OP    <= ID_ALU_OP;
            EX_BRANCH    <= ID_BRANCH;
            EX_MEM_WRITE <= ID_MEM_WRITE;
            EX_MEM_READ  <= ID_MEM_READ;
            EX_WB_SEL    <= ID_WB_SEL;
            EX_WRITE_EN  <= ID_WRITE_EN;
        end
    end

    // Saturating so a long debug run never wraps back to a small number.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            BUBBLE_COUNT <= '0;
        end else if (load_bubble && (BUBBLE_COUNT != '1)) begin
            BUBBLE_COUNT <= BUBBLE_COUNT + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, sel1, sel2;
        logic [4:0]  aluop;
        logic [2:0]  branch;
        logic [1:0]  memw;
        logic [2:0]  memr;
        logic [1:0]  wbsel;
        logic        we;
    } id_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        sel1, sel2;
        logic [4:0]  aluop;
        logic [2:0]  branch;
        logic [1:0]  memw;
        logic [2:0]  memr;
        logic [1:0]  wbsel;
        logic        we;
    } ex_t;

    typedef struct {
        id_t         id;
        logic        st, fl, hz, v;
        logic [31:0] pc;
        logic [4:0]  rd;
        int          cnt;
    } vec_t;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic STALL_IN = 1'b0;
    logic FLUSH_IN = 1'b0;
    id_t  id_cur = '0;

    logic [31:0] EX_PC, EX_DATA1, EX_DATA2, EX_IMM;
    logic [4:0]  EX_RS1, EX_RS2, EX_RD, EX_ALU_OP;
    logic        EX_ALU_SEL1, EX_ALU_SEL2, EX_WRITE_EN, EX_VALID, HAZARD_STALL;
    logic [2:0]  EX_BRANCH, EX_MEM_READ;
    logic [1:0]  EX_MEM_WRITE, EX_WB_SEL;
    logic [15:0] BUBBLE_COUNT;

    logic [31:0] s_pc, s_d1, s_d2, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd, s_aluop;
    logic        s_sel1, s_sel2, s_we, s_valid, s_hz;
    logic [2:0]  s_branch, s_memr;
    logic [1:0]  s_memw, s_wbsel;
    logic [1:0]  s_cnt;

    always #5 CLK = ~CLK;

    id_ex_pipe_reg #(.XLEN(32), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .STALL_IN(STALL_IN), .FLUSH_IN(FLUSH_IN),
        .ID_PC(id_cur.pc), .ID_DATA1(id_cur.d1), .ID_DATA2(id_cur.d2), .ID_IMM(id_cur.imm),
        .ID_RS1(id_cur.rs1), .ID_RS2(id_cur.rs2), .ID_RD(id_cur.rd),
        .ID_RS1_USED(id_cur.u1), .ID_RS2_USED(id_cur.u2),
        .ID_ALU_SEL1(id_cur.sel1), .ID_ALU_SEL2(id_cur.sel2), .ID_ALU_OP(id_cur.aluop),
        .ID_BRANCH(id_cur.branch), .ID_MEM_WRITE(id_cur.memw), .ID_MEM_READ(id_cur.memr),
        .ID_WB_SEL(id_cur.wbsel), .ID_WRITE_EN(id_cur.we),
        .EX_PC(EX_PC), .EX_DATA1(EX_DATA1), .EX_DATA2(EX_DATA2), .EX_IMM(EX_IMM),
        .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .EX_RD(EX_RD),
        .EX_ALU_SEL1(EX_ALU_SEL1), .EX_ALU_SEL2(EX_ALU_SEL2), .EX_ALU_OP(EX_ALU_OP),
        .EX_BRANCH(EX_BRANCH), .EX_MEM_WRITE(EX_MEM_WRITE), .EX_MEM_READ(EX_MEM_READ),
        .EX_WB_SEL(EX_WB_SEL), .EX_WRITE_EN(EX_WRITE_EN), .EX_VALID(EX_VALID),
        .HAZARD_STALL(HAZARD_STALL), .BUBBLE_COUNT(BUBBLE_COUNT)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    id_ex_pipe_reg #(.XLEN(32), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RESET(RESET), .STALL_IN(STALL_IN), .FLUSH_IN(FLUSH_IN),
        .ID_PC(id_cur.pc), .ID_DATA1(id_cur.d1), .ID_DATA2(id_cur.d2), .ID_IMM(id_cur.imm),
        .ID_RS1(id_cur.rs1), .ID_RS2(id_cur.rs2), .ID_RD(id_cur.rd),
        .ID_RS1_USED(id_cur.u1), .ID_RS2_USED(id_cur.u2),
        .ID_ALU_SEL1(id_cur.sel1), .ID_ALU_SEL2(id_cur.sel2), .ID_ALU_OP(id_cur.aluop),
        .ID_BRANCH(id_cur.branch), .ID_MEM_WRITE(id_cur.memw), .ID_MEM_READ(id_cur.memr),
        .ID_WB_SEL(id_cur.wbsel), .ID_WRITE_EN(id_cur.we),
        .EX_PC(s_pc), .EX_DATA1(s_d1), .EX_DATA2(s_d2), .EX_IMM(s_imm),
        .EX_RS1(s_rs1), .EX_RS2(s_rs2), .EX_RD(s_rd),
        .EX_ALU_SEL1(s_sel1), .EX_ALU_SEL2(s_sel2), .EX_ALU_OP(s_aluop),
        .EX_BRANCH(s_branch), .EX_MEM_WRITE(s_memw), .EX_MEM_READ(s_memr),
        .EX_WB_SEL(s_wbsel), .EX_WRITE_EN(s_we), .EX_VALID(s_valid),
        .HAZARD_STALL(s_hz), .BUBBLE_COUNT(s_cnt)
    );

    ex_t act, act_sat;
    assign act = {EX_VALID, EX_PC, EX_DATA1, EX_DATA2, EX_IMM, EX_RS1, EX_RS2, EX_RD,
                  EX_ALU_SEL1, EX_ALU_SEL2, EX_ALU_OP, EX_BRANCH, EX_MEM_WRITE,
                  EX_MEM_READ, EX_WB_SEL, EX_WRITE_EN};
    assign act_sat = {s_valid, s_pc, s_d1, s_d2, s_imm, s_rs1, s_rs2, s_rd,
                      s_sel1, s_sel2, s_aluop, s_branch, s_memw, s_memr, s_wbsel, s_we};

    int   n_tests = 0;
    int   n_fail  = 0;
    ex_t  m;       // reference EX slot
    int   nb;      // reference bubble total (unbounded)
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic logic m_hz(input id_t id);
        // A load in EX whose nonzero destination is read by the ID instruction.
        return m.valid && m.memr != 3'd0 && m.rd != 5'd0 &&
               ((id.u1 && id.rs1 == m.rd) || (id.u2 && id.rs2 == m.rd));
    endfunction

    function automatic id_t mk_id(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                                  input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                  input logic [2:0] memr);
        id_t r;
        r.pc = pc; r.d1 = pc ^ 32'hA5A5_0000; r.d2 = pc + 32'd7; r.imm = {pc[15:0], 16'h00FF};
        r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.u1 = u1; r.u2 = u2;
        r.sel1 = pc[2]; r.sel2 = ~pc[3]; r.aluop = (memr != 0) ? 5'd0 : 5'd1;
        r.branch = 3'd0; r.memw = 2'd0; r.memr = memr; r.wbsel = (memr != 0) ? 2'd1 : 2'd0;
        r.we = 1'b1;
        return r;
    endfunction

    task automatic reset_model();
        m = '0; nb = 0;
    endtask

    // One cycle: drive, check the combinational hazard, clock, then compare
    // every registered output against the reference.
    task automatic step(input id_t id, input logic st, input logic fl,
                        input bit has_tbl, input logic tbl_hz);
        logic hz;
        id_cur = id; STALL_IN = st; FLUSH_IN = fl;
        #1;
        hz = m_hz(id);
        chk("hazard", HAZARD_STALL, hz);
        chk("hazard_sat", s_hz, hz);
        if (has_tbl) chk("hazard_tbl", HAZARD_STALL, tbl_hz);
        @(posedge CLK);
        if (fl || (!st && hz)) begin
            m = '0; nb++;
        end else if (!st) begin
            m.valid = 1'b1; m.pc = id.pc; m.d1 = id.d1; m.d2 = id.d2; m.imm = id.imm;
            m.rs1 = id.rs1; m.rs2 = id.rs2; m.rd = id.rd; m.sel1 = id.sel1; m.sel2 = id.sel2;
            m.aluop = id.aluop; m.branch = id.branch; m.memw = id.memw; m.memr = id.memr;
            m.wbsel = id.wbsel; m.we = id.we;
        end
        #1;
        chk("ex_bundle", act, m);
        chk("ex_bundle_sat", act_sat, m);
        chk("bubble_cnt", BUBBLE_COUNT, (nb > 65535) ? 65535 : nb);
        chk("bubble_cnt_sat", s_cnt, (nb > 3) ? 3 : nb);
    endtask

    initial begin
        id_t rid;
        reset_model();
        // Reset with arbitrary ID inputs.
        id_cur = mk_id(32'hDEAD_BEE0, 5'd3, 1'b1, 5'd4, 1'b1, 5'd9, 3'd2);
        #12;
        chk("rst_valid", EX_VALID, 1'b0);
        chk("rst_we", EX_WRITE_EN, 1'b0);
        chk("rst_memr", EX_MEM_READ, 3'd0);
        chk("rst_cnt", BUBBLE_COUNT, 16'd0);
        chk("rst_hz", HAZARD_STALL, 1'b0);
        chk("rst_bundle", act, ex_t'(0));
        @(posedge CLK); #1 RESET = 1'b1;

        // id, stall, flush, hz, valid, pc, rd, cnt
        vecs.push_back('{mk_id(32'h100, 5'd1, 1, 5'd0, 0, 5'd5, 3'd0), 0, 0, 0, 1, 32'h100, 5'd5, 0});
        vecs.push_back('{mk_id(32'h104, 5'd2, 1, 5'd0, 0, 5'd6, 3'd2), 0, 0, 0, 1, 32'h104, 5'd6, 0});
        vecs.push_back('{mk_id(32'h108, 5'd6, 1, 5'd0, 0, 5'd7, 3'd0), 0, 0, 1, 0, 32'h0,   5'd0, 1});
        vecs.push_back('{mk_id(32'h108, 5'd6, 1, 5'd0, 0, 5'd7, 3'd0), 0, 0, 0, 1, 32'h108, 5'd7, 1});
        vecs.push_back('{mk_id(32'h10C, 5'd1, 1, 5'd0, 0, 5'd0, 3'd2), 0, 0, 0, 1, 32'h10C, 5'd0, 1});
        vecs.push_back('{mk_id(32'h110, 5'd0, 1, 5'd0, 1, 5'd8, 3'd0), 0, 0, 0, 1, 32'h110, 5'd8, 1});
        vecs.push_back('{mk_id(32'h114, 5'd1, 1, 5'd0, 0, 5'd6, 3'd2), 0, 0, 0, 1, 32'h114, 5'd6, 1});
        vecs.push_back('{mk_id(32'h118, 5'd3, 1, 5'd6, 0, 5'd9, 3'd0), 0, 0, 0, 1, 32'h118, 5'd9, 1});
        vecs.push_back('{mk_id(32'h11C, 5'd1, 1, 5'd0, 0, 5'd10, 3'd2), 0, 0, 0, 1, 32'h11C, 5'd10, 1});
        vecs.push_back('{mk_id(32'h120, 5'd1, 0, 5'd10, 1, 5'd11, 3'd0), 1, 1, 1, 0, 32'h0, 5'd0, 2});
        vecs.push_back('{mk_id(32'h124, 5'd1, 0, 5'd0, 0, 5'd12, 3'd0), 1, 0, 0, 0, 32'h0, 5'd0, 2});
        vecs.push_back('{mk_id(32'h128, 5'd1, 0, 5'd0, 0, 5'd13, 3'd0), 0, 0, 0, 1, 32'h128, 5'd13, 2});
        vecs.push_back('{mk_id(32'h200, 5'd1, 0, 5'd0, 0, 5'd14, 3'd2), 1, 0, 0, 1, 32'h128, 5'd13, 2});
        vecs.push_back('{mk_id(32'h204, 5'd13, 1, 5'd0, 0, 5'd15, 3'd0), 1, 0, 0, 1, 32'h128, 5'd13, 2});
        vecs.push_back('{mk_id(32'h208, 5'd2, 1, 5'd13, 1, 5'd16, 3'd1), 1, 0, 0, 1, 32'h128, 5'd13, 2});

        foreach (vecs[i]) begin
            step(vecs[i].id, vecs[i].st, vecs[i].fl, 1'b1, vecs[i].hz);
            chk("tbl_valid", EX_VALID, vecs[i].v);
            chk("tbl_pc", EX_PC, vecs[i].pc);
            chk("tbl_rd", EX_RD, vecs[i].rd);
            chk("tbl_cnt", BUBBLE_COUNT, vecs[i].cnt);
        end

        // Reset while a load-use hold is pending.
        step(mk_id(32'h300, 5'd1, 1, 5'd0, 0, 5'd6, 3'd2), 0, 0, 1'b0, 1'b0);
        id_cur = mk_id(32'h304, 5'd6, 1, 5'd0, 0, 5'd7, 3'd0);
        STALL_IN = 1'b1;
        #1 chk("pre_rst_hz", HAZARD_STALL, 1'b1);
        RESET = 1'b0;
        #1;
        chk("mid_rst_hz", HAZARD_STALL, 1'b0);
        chk("mid_rst_valid", EX_VALID, 1'b0);
        chk("mid_rst_cnt", BUBBLE_COUNT, 16'd0);
        reset_model();
        @(posedge CLK); #1 RESET = 1'b1;
        STALL_IN = 1'b0;

        // Five flushes: narrow counter must stick at 3.
        for (int k = 0; k < 5; k++)
            step(mk_id(32'h400 + 32'(4 * k), 5'd1, 1, 5'd2, 1, 5'd3, 3'd2), k[0], 1'b1, 1'b0, 1'b0);
        chk("sat_cnt2", s_cnt, 2'd3);
        chk("sat_cnt16", BUBBLE_COUNT, 16'd5);

        // Randomized traffic against the reference.
        for (int k = 0; k < 400; k++) begin
            rid = mk_id($urandom, 5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                        1'($urandom), 5'($urandom_range(0, 3)),
                        ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 5)) : 3'd0);
            rid.d1 = $urandom; rid.d2 = $urandom; rid.imm = $urandom;
            rid.aluop = 5'($urandom); rid.branch = 3'($urandom); rid.memw = 2'($urandom);
            rid.wbsel = 2'($urandom); rid.we = 1'($urandom);
            step(rid, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
